// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one registered data-memory port between the CPU load/store
// path and a DMA engine. It uses round-robin arbitration with a bounded DMA burst under lock.
module mem_port_arbiter #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 128,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_lock,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StCOwn, StDOwn, StDBurst} state_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  state_e        state_q, state_d;
  logic [3:0]    burst_cnt_q, burst_cnt_d;
  logic          last_d_q, last_d_d;
  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          rd1_cpu_q, rd1_dma_q, rd2_cpu_q, rd2_dma_q;

  always_comb begin
    cpu_gnt     = 1'b0;
    dma_gnt     = 1'b0;
    state_d     = StIdle;
    burst_cnt_d = '0;
    last_d_d    = last_d_q;

    if (cpu_req && dma_req) begin
      // Lock priority only holds while the DMA keeps dma_lock asserted.
      if (state_q == StDBurst && dma_lock) begin
        if (burst_cnt_q < MaxBurst) dma_gnt = 1'b1;
        else                        cpu_gnt = 1'b1;
      end else if (last_d_q) begin
        cpu_gnt = 1'b1;
      end else begin
        dma_gnt = 1'b1;
      end
    end else begin
      cpu_gnt = cpu_req;
      dma_gnt = dma_req;
    end

    if (cpu_gnt) begin
      state_d  = StCOwn;
      last_d_d = 1'b0;
    end else if (dma_gnt) begin
      last_d_d = 1'b1;
      if (dma_lock) begin
        state_d     = StDBurst;
        burst_cnt_d = (burst_cnt_q == MaxBurst) ? MaxBurst : burst_cnt_q + 4'd1;
      end else begin
        state_d = StDOwn;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      burst_cnt_q <= '0;
      last_d_q    <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd1_cpu_q   <= 1'b0;
      rd1_dma_q   <= 1'b0;
      rd2_cpu_q   <= 1'b0;
      rd2_dma_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_d_q    <= last_d_d;
      mem_en_q    <= cpu_gnt | dma_gnt;
      mem_we_q    <= (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
      if (cpu_gnt) begin
        mem_addr_q  <= cpu_addr;
        mem_wdata_q <= cpu_wdata;
      end else if (dma_gnt) begin
        mem_addr_q  <= dma_addr;
        mem_wdata_q <= dma_wdata;
      end
      // Read tag pipe: stage 1 lines up with mem_en, stage 2 with mem_rdata.
      rd1_cpu_q <= cpu_gnt & ~cpu_we;
      rd1_dma_q <= dma_gnt & ~dma_we;
      rd2_cpu_q <= rd1_cpu_q;
      rd2_dma_q <= rd1_dma_q;
    end
  end

  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign cpu_rvalid = rd2_cpu_q;
  assign dma_rvalid = rd2_dma_q;
  assign rdata      = mem_rdata;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random traffic,
// compared against a cycle-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int MaxB = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [15:0]  cpu_addr;
  logic [127:0] cpu_wdata;
  logic         dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [15:0]  dma_addr;
  logic [127:0] dma_wdata;
  logic [127:0] rdata, mem_wdata, mem_rdata;
  logic         mem_en, mem_we;
  logic [15:0]  mem_addr;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit           m_last_d;
  int           m_run;
  bit           m_gc, m_gd;
  bit           e_en, e_we, e_rc1, e_rd1, e_rc2, e_rd2;
  logic [15:0]  e_addr;
  logic [127:0] e_wd;

  mem_port_arbiter #(.AW(16), .DW(128), .MAX_BURST(MaxB)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_lock   (dma_lock),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .rdata      (rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last_d = 1'b1;
    m_run    = 0;
    m_gc     = 1'b0;
    m_gd     = 1'b0;
    e_en = 0; e_we = 0; e_rc1 = 0; e_rd1 = 0; e_rc2 = 0; e_rd2 = 0;
    e_addr = '0;
    e_wd   = '0;
  endtask

  // One clock cycle: drive requests, check grants, advance model, check registered outputs.
  // exp_g < 0 means no directed grant expectation; else bit0 = CPU, bit1 = DMA.
  task automatic step(input logic c, input logic cw, input logic [15:0] ca,
                      input logic [127:0] cd, input logic d, input logic dw,
                      input logic [15:0] da, input logic [127:0] dd, input logic lk,
                      input int exp_g);
    cpu_req = c; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = d; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_lock = lk;
    #1;
    m_gc = 1'b0;
    m_gd = 1'b0;
    if (c && !d)      m_gc = 1'b1;
    else if (d && !c) m_gd = 1'b1;
    else if (c && d) begin
      if (m_run > 0 && lk) begin
        if (m_run < MaxB) m_gd = 1'b1;
        else              m_gc = 1'b1;
      end else if (m_last_d) m_gc = 1'b1;
      else                   m_gd = 1'b1;
    end
    chk("cpu_gnt", cpu_gnt, m_gc);
    chk("dma_gnt", dma_gnt, m_gd);
    chk("cpu_stall", cpu_stall, c & ~m_gc);
    if (exp_g >= 0) chk("dir_gnt", {dma_gnt, cpu_gnt}, exp_g[1:0]);

    e_rc2 = e_rc1;
    e_rd2 = e_rd1;
    e_rc1 = m_gc & ~cw;
    e_rd1 = m_gd & ~dw;
    e_en  = m_gc | m_gd;
    e_we  = m_gc ? cw : (m_gd ? dw : 1'b0);
    if (m_gc) begin e_addr = ca; e_wd = cd; end
    if (m_gd) begin e_addr = da; e_wd = dd; end
    if (m_gd && lk) m_run = (m_run + 1 > MaxB) ? MaxB : m_run + 1;
    else            m_run = 0;
    if (m_gc) m_last_d = 1'b0;
    if (m_gd) m_last_d = 1'b1;

    @(posedge clk);
    #1;
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("cpu_rvalid", cpu_rvalid, e_rc2);
    chk("dma_rvalid", dma_rvalid, e_rd2);
    chk("rdata", rdata, mem_rdata);
  endtask

  task automatic idle();
    step(0, 0, 16'h0, '0, 0, 0, 16'h0, '0, 0, 0);
  endtask

  logic         rc, rcw, rd, rdw, rlk;
  logic [15:0]  rca, rda;
  logic [127:0] rcd, rdd;
  logic [9:0]   rr_pat;
  logic [21:0]  burst_pat;

  initial begin
    // Reset held with both requests active
    reset = 1'b0;
    mem_rdata = '0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h5; cpu_wdata = '1;
    dma_req = 1; dma_we = 1; dma_addr = 16'h7; dma_wdata = '1; dma_lock = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dma_rvalid", dma_rvalid, 0);
    reset = 1'b1;
    // First tie after reset goes to the CPU
    step(1, 1, 16'h5, '1, 1, 1, 16'h7, '1, 0, 1);
    idle();
    idle();

    // Single CPU read
    step(1, 0, 16'h0010, '0, 0, 0, 16'h0, '0, 0, 1);
    chk("rd_vis_en", mem_en, 1);
    chk("rd_vis_addr", mem_addr, 16'h0010);
    mem_rdata = 128'hDEAD;
    idle();
    chk("rd_cpu_rvalid", cpu_rvalid, 1);
    chk("rd_dma_rvalid", dma_rvalid, 0);
    chk("rd_rdata", rdata, 128'hDEAD);
    idle();

    // Round-robin: make DMA last owner, then six contended cycles C,D,C,D,C,D
    step(0, 0, 16'h0, '0, 1, 0, 16'h0200, '0, 0, 2);
    rr_pat = 10'b10_01_10_01_10;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 16'h0030, '0, 1, 0, 16'h0300, '0, 0, 1);
      step(1, 0, 16'h0030, '0, 1, 0, 16'h0300, '0, 0, 2);
      if (i == 2) break;
    end
    idle();

    // Locked burst: C (round-robin), then D,D,D,D,C,D,D,D,D,C
    step(0, 0, 16'h0, '0, 1, 0, 16'h0200, '0, 0, 2);
    burst_pat = 22'b01_10_10_10_10_01_10_10_10_10_01;
    for (int i = 10; i >= 0; i--) begin
      rr_pat[1:0] = burst_pat[2*i +: 2];
      step(1, 0, 16'h0040, '0, 1, 0, 16'h0400, '0, 1, int'(rr_pat[1:0]));
    end
    idle();

    // DMA write
    step(0, 0, 16'h0, '0, 1, 1, 16'h0100, 128'h1234, 0, 2);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 16'h0100);
    chk("wr_mem_wdata", mem_wdata, 128'h1234);
    idle();
    idle();

    // Reset while a CPU read is in flight
    step(1, 0, 16'h0020, '0, 0, 0, 16'h0, '0, 0, 1);
    reset = 1'b0;
    cpu_req = 0;
    #1;
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_cpu_rvalid", cpu_rvalid, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("mid_rst_cpu_rvalid", cpu_rvalid, 0);
      chk("mid_rst_dma_rvalid", dma_rvalid, 0);
    end
    reset = 1'b1;
    model_reset();

    // Random traffic with held requests and toggling lock
    rc = 0; rd = 0; rlk = 0;
    rcw = 0; rdw = 0; rca = '0; rda = '0; rcd = '0; rdd = '0;
    for (int i = 0; i < 500; i++) begin
      if (!rc || m_gc) begin
        rc  = ($urandom_range(0, 3) != 0);
        rcw = 1'($urandom);
        rca = 16'($urandom);
        rcd = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!rd || m_gd) begin
        rd  = ($urandom_range(0, 3) != 0);
        rdw = 1'($urandom);
        rda = 16'($urandom);
        rdd = {$urandom, $urandom, $urandom, $urandom};
      end
      if ($urandom_range(0, 11) == 0) rlk = ~rlk;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      step(rc, rcw, rca, rcd, rd, rdw, rda, rdd, rlk, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
